// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants: FSM state encodings, screen size, empty-pixel sentinel
package game_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_COOLDOWN  = 2'd2;
    localparam logic [1:0] ST_GAME_OVER = 2'd3;

    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;

    localparam logic [11:0] NO_PIXEL = 12'd0;

endpackage

// File: rtl/pointer_hit_cmp.sv
// rtl/pointer_hit_cmp.sv - two-stage registered compare of obstacle pixels against the per-frame pointer box
module pointer_hit_cmp #(
    parameter int CURSOR_W = 16,
    parameter int CURSOR_H = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic        overlap,
    output logic [11:0] box_x,
    output logic [11:0] box_y
);
    import game_pkg::*;

    logic [11:0] s1_x;
    logic [11:0] s1_y;
    logic        s1_v;
    logic [12:0] x_lo, x_hi, y_lo, y_hi;
    logic        in_x, in_y;

    // 13-bit bounds so a box near the right/bottom edge cannot wrap to zero
    always_comb begin
        x_lo = {1'b0, box_x};
        y_lo = {1'b0, box_y};
        x_hi = x_lo + 13'(CURSOR_W - 1);
        y_hi = y_lo + 13'(CURSOR_H - 1);
        in_x = ({1'b0, s1_x} >= x_lo) && ({1'b0, s1_x} <= x_hi);
        in_y = ({1'b0, s1_y} >= y_lo) && ({1'b0, s1_y} <= y_hi);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            box_x   <= 12'd0;
            box_y   <= 12'd0;
            s1_x    <= 12'd0;
            s1_y    <= 12'd0;
            s1_v    <= 1'b0;
            overlap <= 1'b0;
        end else begin
            if (frame_start) begin
                box_x <= mouse_xpos;
                box_y <= mouse_ypos;
            end
            s1_x    <= obstacle_x;
            s1_y    <= obstacle_y;
            s1_v    <= (obstacle_x | obstacle_y) != NO_PIXEL;
            overlap <= s1_v && in_x && in_y;
        end
    end

endmodule

// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - per-frame pointer hit detection with lives, cooldown and game over
// Optional GOD_MODE_EN: hits still pulse and start cooldown but never cost a life.
module collision_detector #(
    parameter int CURSOR_W        = 16,
    parameter int CURSOR_H        = 16,
    parameter int MAX_LIVES       = 3,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        game_on,
    output logic        hit,
    output logic [2:0]  lives,
    output logic        invuln,
    output logic        game_over
);
    import game_pkg::*;

    logic        frame_start;
    logic        overlap;
    logic        frame_hit;
    logic        take_hit;
    logic [1:0]  state, state_next;
    logic [7:0]  cool_cnt;
    logic [2:0]  lives_dec;
    logic [11:0] box_x, box_y;
    logic        unused_box;

    assign frame_start = (hcount_in == 12'd0) && (vcount_in == 12'd0);
    assign unused_box  = ^{box_x, box_y};

    pointer_hit_cmp #(
        .CURSOR_W (CURSOR_W),
        .CURSOR_H (CURSOR_H)
    ) u_cmp (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .obstacle_x  (obstacle_x),
        .obstacle_y  (obstacle_y),
        .mouse_xpos  (mouse_xpos),
        .mouse_ypos  (mouse_ypos),
        .overlap     (overlap),
        .box_x       (box_x),
        .box_y       (box_y)
    );

    // An overlap landing on frame_start belongs to the frame that is just beginning
    always_ff @(posedge clk) begin
        if (rst || !game_on)
            frame_hit <= 1'b0;
        else if (frame_start)
            frame_hit <= overlap;
        else
            frame_hit <= frame_hit | overlap;
    end

    assign take_hit = (state == ST_ARMED) && game_on && frame_start && frame_hit;

`ifdef GOD_MODE_EN
    assign lives_dec = lives;
`else
    assign lives_dec = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (frame_start && game_on)
                    state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!game_on)
                    state_next = ST_IDLE;
                else if (take_hit)
`ifdef GOD_MODE_EN
                    state_next = ST_COOLDOWN;
`else
                    state_next = (lives_dec == 3'd0) ? ST_GAME_OVER : ST_COOLDOWN;
`endif
            end
            ST_COOLDOWN: begin
                if (!game_on)
                    state_next = ST_IDLE;
                else if (frame_start && cool_cnt <= 8'd1)
                    state_next = ST_ARMED;
            end
            ST_GAME_OVER: begin
                if (frame_start && !game_on)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        invuln    = (state == ST_COOLDOWN);
        game_over = (state == ST_GAME_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit      <= 1'b0;
            lives    <= 3'(MAX_LIVES);
            cool_cnt <= 8'd0;
        end else begin
            hit <= take_hit;
            if (state_next == ST_IDLE)
                lives <= 3'(MAX_LIVES);
            else if (take_hit)
                lives <= lives_dec;
            if (state_next == ST_IDLE)
                cool_cnt <= 8'd0;
            else if (take_hit)
                cool_cnt <= 8'(COOLDOWN_FRAMES);
            else if ((state == ST_COOLDOWN) && frame_start && (cool_cnt != 8'd0))
                cool_cnt <= cool_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// tb/tb_collision_detector.sv - scoreboard bench for collision_detector on a small 16x4 raster
module tb_collision_detector;

    localparam int H = 16;
    localparam int V = 4;
    localparam int HIT_TOTAL = 6;
`ifdef GOD_MODE_EN
    localparam bit GOD = 1'b1;
`else
    localparam bit GOD = 1'b0;
`endif
    localparam int L2 = GOD ? 3 : 2;
    localparam int L1 = GOD ? 3 : 1;
    localparam int L0 = GOD ? 3 : 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] hc, vc, ox, oy, mx, my;
    logic        game_on;
    logic        hit;
    logic [2:0]  lives;
    logic        invuln;
    logic        game_over;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int hit_cnt = 0;

    typedef struct {
        int          at;
        string       name;
        logic        h;
        logic [2:0]  l;
        logic        inv;
        logic        go;
    } exp_t;

    exp_t sbq[$];

    collision_detector dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_in  (hc),
        .vcount_in  (vc),
        .obstacle_x (ox),
        .obstacle_y (oy),
        .mouse_xpos (mx),
        .mouse_ypos (my),
        .game_on    (game_on),
        .hit        (hit),
        .lives      (lives),
        .invuln     (invuln),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    initial begin : raster
        hc = 12'd0;
        vc = 12'd0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (hc == 12'(H - 1)) begin
                hc = 12'd0;
                vc = (vc == 12'(V - 1)) ? 12'd0 : vc + 12'd1;
            end else begin
                hc = hc + 12'd1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (hit === 1'b1)
            hit_cnt++;
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            e = sbq.pop_front();
            checks++;
            if (hit !== e.h || lives !== e.l || invuln !== e.inv || game_over !== e.go) begin
                errors++;
                $display("FAIL %s @cyc %0d: got hit=%0b lives=%0d invuln=%0b game_over=%0b, want hit=%0b lives=%0d invuln=%0b game_over=%0b",
                         e.name, cyc, hit, lives, invuln, game_over, e.h, e.l, e.inv, e.go);
            end
        end
    end

    task automatic expect_at(input int at, input string name, input logic h,
                             input int l, input logic inv, input logic go);
        exp_t e;
        e.at   = at;
        e.name = name;
        e.h    = h;
        e.l    = 3'(l);
        e.inv  = inv;
        e.go   = go;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Returns in the cycle where frame_start is being presented
    task automatic next_frame(output int c);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(hc == 12'd0 && vc == 12'd0) && n < 4 * H * V);
        if (n >= 4 * H * V) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: no frame_start within %0d cycles", n);
        end
        c = cyc;
    endtask

    task automatic pix(input int x, input int y);
        step(5);
        ox = 12'(x);
        oy = 12'(y);
        step(1);
        ox = 12'd0;
        oy = 12'd0;
    endtask

    initial begin : stim
        int c;
        rst = 1'b1; game_on = 1'b0; mx = 12'd400; my = 12'd400; ox = 12'd0; oy = 12'd0;
        step(3);
        expect_at(cyc, "reset", 0, 3, 0, 0);
        step(1);
        rst = 1'b0;
        game_on = 1'b1;

        next_frame(c); expect_at(c + 1, "arm", 0, 3, 0, 0);
        pix(416, 400); pix(399, 405); pix(405, 416); pix(400, 399);
        next_frame(c); expect_at(c + 1, "just_outside", 0, 3, 0, 0);
        step(1); mx = 12'd0; my = 12'd0;
        next_frame(c);
        step(1); mx = 12'd400; my = 12'd400;
        next_frame(c); expect_at(c + 1, "no_pixel_at_origin", 0, 3, 0, 0);

        pix(405, 410);
        next_frame(c);
        expect_at(c + 1, "first_hit", 1, L2, 1, 0);
        expect_at(c + 2, "hit_one_cycle", 0, L2, 1, 0);
        for (int k = 1; k <= 60; k++) begin
            next_frame(c);
            if (k == 30) pix(405, 410);
            if (k == 31) expect_at(c + 1, "cooldown_ignores_hit", 0, L2, 1, 0);
            if (k == 59) begin
                expect_at(c + 1, "cooldown_last", 0, L2, 1, 0);
                pix(405, 410);
            end
            if (k == 60) begin
                expect_at(c + 1, "rearm_after_cooldown", 0, L2, 0, 0);
                pix(415, 415);
            end
        end
        next_frame(c); expect_at(c + 1, "corner_hit", 1, L1, 1, 0);

        step(8); rst = 1'b1;
        step(1); rst = 1'b0;
        expect_at(cyc, "mid_frame_reset", 0, 3, 0, 0);
        next_frame(c); expect_at(c + 1, "arm_after_reset", 0, 3, 0, 0);

        pix(405, 405);
        step(3); game_on = 1'b0;
        expect_at(cyc + 1, "drop_armed", 0, 3, 0, 0);
        next_frame(c); expect_at(c + 1, "drop_armed_frame", 0, 3, 0, 0);
        step(1); game_on = 1'b1;
        next_frame(c); expect_at(c + 1, "arm_again", 0, 3, 0, 0);
        pix(405, 405);
        next_frame(c); expect_at(c + 1, "hit_again", 1, L2, 1, 0);
        step(8); game_on = 1'b0;
        expect_at(cyc + 1, "drop_cooldown", 0, 3, 0, 0);
        next_frame(c); expect_at(c + 1, "idle_hold", 0, 3, 0, 0);
        step(1); game_on = 1'b1;

        next_frame(c); expect_at(c + 1, "t4_arm", 0, 3, 0, 0);
        for (int b = 1; b <= 125; b++) begin
            pix(405, 410);
            next_frame(c);
            if (b == 1)   expect_at(c + 1, "t4_hit1", 1, L2, 1, 0);
            if (b == 61)  expect_at(c + 1, "t4_rearm", 0, L2, 0, 0);
            if (b == 62)  expect_at(c + 1, "t4_hit2", 1, L1, 1, 0);
            if (b == 123) expect_at(c + 1, "t4_hit3", 1, L0, GOD, !GOD);
            if (b == 125) expect_at(c + 1, "t4_after", 0, L0, GOD, !GOD);
        end
        step(1); game_on = 1'b0;
        next_frame(c); expect_at(c + 1, "t4_idle", 0, 3, 0, 0);
        step(4);

        checks++;
        if (hit_cnt != HIT_TOTAL) begin
            errors++;
            $display("FAIL hit_total: got %0d pulses, want %0d", hit_cnt, HIT_TOTAL);
        end
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation never sampled", e.name);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
